// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one cache port among CHANNELS LSU requesters, one request at a time.
// Round-robin by default; define LSU_ARB_FIXED_PRIO_EN for lowest-index-first priority.
module lsu_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            req_read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  req_read_address,
  input  logic [CHANNELS-1:0]            req_write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  req_write_address,
  input  logic [CHANNELS*DATA_BITS-1:0]  req_write_data,
  output logic [CHANNELS-1:0]            req_read_ready,
  output logic [CHANNELS*DATA_BITS-1:0]  req_read_data,
  output logic [CHANNELS-1:0]            req_write_ready,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_address,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic                           busy,
  output logic [$clog2(CHANNELS)-1:0]    grant_id
);
  localparam int IW = $clog2(CHANNELS);
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;
  state_t state;
  logic serve_read, served;
  logic [IW-1:0] win;
  logic [CHANNELS-1:0] elig;
  assign elig   = req_read_valid | req_write_valid;
  assign busy   = state != IDLE;
  assign served = serve_read ? req_read_valid[grant_id] : req_write_valid[grant_id];
`ifdef LSU_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (elig[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] rr_ptr;
  // scan offsets downward so the smallest offset from rr_ptr wins
  always_comb begin
    win = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (elig[(int'(rr_ptr) + i) % CHANNELS]) win = IW'((int'(rr_ptr) + i) % CHANNELS);
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      serve_read        <= 1'b0;
      grant_id          <= '0;
      req_read_ready    <= '0;
      req_write_ready   <= '0;
      req_read_data     <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
`ifndef LSU_ARB_FIXED_PRIO_EN
      rr_ptr            <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|elig) begin
          grant_id          <= win;
          serve_read        <= req_read_valid[win];
          mem_read_address  <= req_read_address[win*ADDR_BITS +: ADDR_BITS];
          mem_write_address <= req_write_address[win*ADDR_BITS +: ADDR_BITS];
          mem_write_data    <= req_write_data[win*DATA_BITS +: DATA_BITS];
          mem_read_valid    <= req_read_valid[win];
          mem_write_valid   <= !req_read_valid[win];
          state             <= req_read_valid[win] ? READ_WAIT : WRITE_WAIT;
        end
        READ_WAIT: if (mem_read_ready) begin
          req_read_data[grant_id*DATA_BITS +: DATA_BITS] <= mem_read_data;
          req_read_ready[grant_id] <= 1'b1;
          mem_read_valid           <= 1'b0;
          state                    <= RELAY;
        end
        WRITE_WAIT: if (mem_write_ready) begin
          req_write_ready[grant_id] <= 1'b1;
          mem_write_valid           <= 1'b0;
          state                     <= RELAY;
        end
        RELAY: begin
          req_read_ready  <= '0;
          req_write_ready <= '0;
          if (!served) begin
`ifndef LSU_ARB_FIXED_PRIO_EN
            rr_ptr <= (grant_id == IW'(CHANNELS - 1)) ? '0 : grant_id + 1'b1;
`endif
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed and randomized checks of lsu_arbiter against a transaction-level model.
module tb_lsu_arbiter;
  localparam int AB = 8, DB = 8, C = 4;
  logic clk = 0, reset;
  logic [C-1:0] req_read_valid, req_write_valid, req_read_ready, req_write_ready;
  logic [C*AB-1:0] req_read_address, req_write_address;
  logic [C*DB-1:0] req_write_data, req_read_data;
  logic mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready, busy;
  logic [AB-1:0] mem_read_address, mem_write_address;
  logic [DB-1:0] mem_read_data, mem_write_data;
  logic [1:0] grant_id;

  lsu_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset),
    .req_read_valid(req_read_valid), .req_read_address(req_read_address),
    .req_write_valid(req_write_valid), .req_write_address(req_write_address),
    .req_write_data(req_write_data), .req_read_ready(req_read_ready),
    .req_read_data(req_read_data), .req_write_ready(req_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // requester-side view and memory model
  bit rv[C], wv[C];
  logic [AB-1:0] raddr[C], waddr[C];
  logic [DB-1:0] wdata[C], lane_exp[C];
  logic [DB-1:0] mem[256];
  int ptr, n_pass, n_tot;

  always_comb begin
    req_read_valid = '0; req_write_valid = '0;
    req_read_address = '0; req_write_address = '0; req_write_data = '0;
    for (int i = 0; i < C; i++) begin
      req_read_valid[i] = rv[i];
      req_write_valid[i] = wv[i];
      req_read_address[i*AB +: AB] = raddr[i];
      req_write_address[i*AB +: AB] = waddr[i];
      req_write_data[i*DB +: DB] = wdata[i];
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [C*DB-1:0] lanes();
    logic [C*DB-1:0] v = '0;
    for (int i = 0; i < C; i++) v[i*DB +: DB] = lane_exp[i];
    return v;
  endfunction

  // winner from the arbitration rule: first eligible at or above the pointer, wrapping
  function automatic int pick();
    int p = ptr;
`ifdef LSU_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int o = 0; o < C; o++) if (rv[(p+o)%C] || wv[(p+o)%C]) return (p + o) % C;
    return -1;
  endfunction

  task automatic arrive();
    for (int i = 0; i < C; i++) if (!rv[i] && !wv[i] && $urandom_range(0, 3) == 0) begin
      int k = $urandom_range(0, 2);
      rv[i] = k != 1; wv[i] = k != 0;
      raddr[i] = AB'($urandom); waddr[i] = AB'($urandom); wdata[i] = DB'($urandom);
    end
  endtask

  // precondition: arbiter idle and at least one request driven in this cycle
  task automatic serve_one(input int lat, input int hold, input bit rand_arrive, output int w, output bit rd);
    w = pick(); rd = rv[w];
    cycle();
    chk("grant_busy", busy, 1);
    chk("grant_id", grant_id, w);
    chk("grant_rvalid", mem_read_valid, rd);
    chk("grant_wvalid", mem_write_valid, !rd);
    if (rd) chk("grant_raddr", mem_read_address, raddr[w]);
    else begin
      chk("grant_waddr", mem_write_address, waddr[w]);
      chk("grant_wdata", mem_write_data, wdata[w]);
    end
    repeat (lat - 1) begin
      if (rd) mem_write_ready = 1'($urandom); else mem_read_ready = 1'($urandom);
      cycle();
      chk("wait_valid", rd ? mem_read_valid : mem_write_valid, 1);
      chk("wait_noready", {req_read_ready, req_write_ready}, 0);
    end
    mem_read_ready = rd; mem_write_ready = !rd;
    mem_read_data = mem[raddr[w]];
    cycle();
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = '0;
    if (rd) lane_exp[w] = mem[raddr[w]]; else mem[waddr[w]] = wdata[w];
    chk("pulse_rready", req_read_ready, rd ? (C'(1) << w) : '0);
    chk("pulse_wready", req_write_ready, rd ? '0 : (C'(1) << w));
    chk("pulse_rdata", req_read_data, lanes());
    chk("pulse_valids", {mem_read_valid, mem_write_valid}, 0);
    if (rand_arrive) arrive();
    repeat (hold) begin
      cycle();
      chk("hold_busy", busy, 1);
      chk("hold_ready", {req_read_ready, req_write_ready}, 0);
      chk("hold_valids", {mem_read_valid, mem_write_valid}, 0);
    end
    if (rd) rv[w] = 0; else wv[w] = 0;
    cycle();
    chk("exit_busy", busy, 0);
    chk("exit_ready", {req_read_ready, req_write_ready}, 0);
    ptr = (w + 1) % C;
  endtask

  initial begin
    int w;
    bit rd;
    int order[5];
`ifdef LSU_ARB_FIXED_PRIO_EN
    order = '{0, 0, 1, 2, 3};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    n_pass = 0; n_tot = 0; ptr = 0;
    mem_read_ready = 0; mem_write_ready = 0; mem_read_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = DB'($urandom);
    for (int i = 0; i < C; i++) begin
      rv[i] = 1; wv[i] = 1; raddr[i] = AB'(i); waddr[i] = AB'(i); wdata[i] = DB'(i); lane_exp[i] = '0;
    end
    // reset held with every request high
    reset = 0;
    cycle(); cycle();
    chk("rst_rready", req_read_ready, 0);
    chk("rst_wready", req_write_ready, 0);
    chk("rst_rdata", req_read_data, 0);
    chk("rst_mrv", mem_read_valid, 0);
    chk("rst_mra", mem_read_address, 0);
    chk("rst_mwv", mem_write_valid, 0);
    chk("rst_mwa", mem_write_address, 0);
    chk("rst_mwd", mem_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    for (int i = 0; i < C; i++) begin rv[i] = 0; wv[i] = 0; end
    reset = 1;
    cycle();
    // single read on ch2, 3-cycle downstream latency
    mem[8'h10] = 8'hA5;
    rv[2] = 1; raddr[2] = 8'h10;
    serve_one(3, 0, 0, w, rd);
    chk("single_w", w, 2);
    chk("single_lane2", req_read_data[23:16], 8'hA5);
    chk("single_gid_hold", grant_id, 2);
    // pointer at 3, only ch1 requesting, requester holds valid two extra cycles
    rv[1] = 1; raddr[1] = 8'h44;
    serve_one(1, 2, 0, w, rd);
    chk("wrap_w", w, 1);
    // reset during READ_WAIT abandons the transaction
    rv[2] = 1; raddr[2] = 8'h55;
    cycle();
    chk("midrst_pre", mem_read_valid, 1);
    reset = 0; rv[2] = 0;
    cycle();
    chk("midrst_mrv", mem_read_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gid", grant_id, 0);
    reset = 1; mem_read_ready = 1; mem_read_data = 8'hEE;
    cycle();
    mem_read_ready = 0; mem_read_data = '0;
    chk("midrst_nopulse", req_read_ready, 0);
    chk("midrst_busy2", busy, 0);
    chk("midrst_rdata", req_read_data, 0);
    for (int i = 0; i < C; i++) lane_exp[i] = '0;
    ptr = 0;
    // all four channels write; ch0 re-requests after it is served
    for (int i = 0; i < C; i++) begin
      wv[i] = 1; waddr[i] = AB'(8'h20 + i); wdata[i] = DB'(8'h30 + i);
    end
    for (int n = 0; n < 5; n++) begin
      serve_one(1, 0, 0, w, rd);
      chk("rr_order", w, order[n]);
      chk("rr_isw", rd, 0);
      if (n == 0) wv[0] = 1;
    end
    for (int i = 0; i < C; i++) chk("rr_mem", mem[8'h20 + i], 8'h30 + i);
    // read and write together on ch1: read first, then write
    rv[1] = 1; wv[1] = 1; raddr[1] = 8'h21; waddr[1] = 8'h77; wdata[1] = 8'h5C;
    serve_one(2, 0, 0, w, rd);
    chk("rw_first_w", w, 1);
    chk("rw_first_rd", rd, 1);
    chk("rw_first_data", req_read_data[15:8], 8'h31);
    serve_one(1, 1, 0, w, rd);
    chk("rw_second_w", w, 1);
    chk("rw_second_rd", rd, 0);
    chk("rw_mem", mem[8'h77], 8'h5C);
    // randomized traffic
    repeat (150) begin
      arrive();
      if (pick() >= 0) serve_one($urandom_range(1, 3), $urandom_range(0, 2), 1, w, rd);
      else begin
        mem_read_ready = 1; mem_write_ready = 1;
        cycle();
        mem_read_ready = 0; mem_write_ready = 0;
        chk("idle_spurious", {busy, req_read_ready, req_write_ready}, 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
